// File: rtl/link_table_addr_manager.sv
// Linked-list FIFO of page numbers (data table or free-page table) held in a next-pointer array.
// Optional `LINK_MGR_ERR_FLAG_EN adds sticky err_underflow / err_overflow outputs.
module link_table_addr_manager #(
  parameter int ADDR_PAGE_NUM_LOG = 12,
  parameter bit INIT_FULL         = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         table_read_req,
  input  logic                         table_write_req,
  input  logic [ADDR_PAGE_NUM_LOG-1:0] table_write_addr,
  output logic [ADDR_PAGE_NUM_LOG-1:0] table_head_addr,
  output logic [ADDR_PAGE_NUM_LOG-1:0] table_last_addr,
  output logic                         table_empty,
  output logic                         table_full,
  output logic [ADDR_PAGE_NUM_LOG:0]   table_count,
  output logic                         table_busy
`ifdef LINK_MGR_ERR_FLAG_EN
  ,
  output logic                         err_underflow,
  output logic                         err_overflow
`endif
);

  localparam int LOG = ADDR_PAGE_NUM_LOG;
  localparam int N   = 1 << LOG;
  localparam logic [LOG:0]   CNT_FULL = {1'b1, {LOG{1'b0}}};
  localparam logic [LOG:0]   CNT_RST  = INIT_FULL ? CNT_FULL : '0;
  localparam logic [LOG-1:0] LAST_RST = INIT_FULL ? {LOG{1'b1}} : '0;
  localparam logic [LOG-1:0] PAGE_MAX = {LOG{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t STATE_RST = INIT_FULL ? S_INIT : S_RUN;

  state_t         state_q, state_d;
  logic [LOG-1:0] init_cnt_q, init_cnt_d;
  logic [LOG-1:0] head_q, head_d;
  logic [LOG-1:0] last_q, last_d;
  logic [LOG:0]   count_q, count_d;
  logic           empty_q, empty_d;
  logic           full_q, full_d;
  logic           busy_q, busy_d;
  logic           underflow_ev, overflow_ev;

  logic [LOG-1:0] next_mem [N];
  logic           mem_we;
  logic [LOG-1:0] mem_waddr;
  logic [LOG-1:0] mem_wdata;

  logic pop_ok, push_ok;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    head_d       = head_q;
    last_d       = last_q;
    count_d      = count_q;
    mem_we       = 1'b0;
    mem_waddr    = last_q;
    mem_wdata    = table_write_addr;
    pop_ok       = 1'b0;
    push_ok      = 1'b0;
    underflow_ev = 1'b0;
    overflow_ev  = 1'b0;

    case (state_q)
      S_INIT: begin
        // Requests are dropped while the free list is being threaded 0->1->..->N-1.
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = init_cnt_q + 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == PAGE_MAX) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end
      end
      default: begin
        pop_ok       = table_read_req && (count_q != '0);
        push_ok      = table_write_req && ((count_q != CNT_FULL) || table_read_req);
        underflow_ev = table_read_req && (count_q == '0);
        overflow_ev  = table_write_req && !table_read_req && (count_q == CNT_FULL);

        if (pop_ok && (count_q != 1))
          head_d = next_mem[head_q];
        if (push_ok) begin
          last_d = table_write_addr;
          // With no surviving element the new page becomes the head; otherwise link it behind last.
          if ((count_q == '0) || ((count_q == 1) && pop_ok))
            head_d = table_write_addr;
          else
            mem_we = 1'b1;
        end

        if (push_ok && !pop_ok)
          count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok)
          count_d = count_q - 1'b1;
      end
    endcase

    busy_d  = (state_d == S_INIT);
    empty_d = (state_d == S_INIT) || (count_d == '0);
    full_d  = (state_d == S_RUN) && (count_d == CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STATE_RST;
      init_cnt_q <= '0;
      head_q     <= '0;
      last_q     <= LAST_RST;
      count_q    <= CNT_RST;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      busy_q     <= INIT_FULL;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      head_q     <= head_d;
      last_q     <= last_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      next_mem[mem_waddr] <= mem_wdata;
  end

  assign table_head_addr = head_q;
  assign table_last_addr = last_q;
  assign table_count     = count_q;
  assign table_empty     = empty_q;
  assign table_full      = full_q;
  assign table_busy      = busy_q;

`ifdef LINK_MGR_ERR_FLAG_EN
  logic err_underflow_q, err_underflow_d;
  logic err_overflow_q, err_overflow_d;

  always_comb begin
    err_underflow_d = err_underflow_q | underflow_ev;
    err_overflow_d  = err_overflow_q | overflow_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;
`else
  logic unused_err;
  assign unused_err = underflow_ev ^ overflow_ev;
`endif

endmodule

// File: tb/tb_link_table_addr_manager.sv
// Directed bench: instance a is INIT_FULL=1 (free-page table), instance b is INIT_FULL=0 (data table); LOG=3.
module tb_link_table_addr_manager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       rst_a, rd_a, wr_a;
  logic [2:0] addr_a, head_a, last_a;
  logic [3:0] count_a;
  logic       empty_a, full_a, busy_a;
  logic       rst_b, rd_b, wr_b;
  logic [2:0] addr_b, head_b, last_b;
  logic [3:0] count_b;
  logic       empty_b, full_b, busy_b;
`ifdef LINK_MGR_ERR_FLAG_EN
  logic       unf_a, ovf_a, unf_b, ovf_b;
`endif

  link_table_addr_manager #(.ADDR_PAGE_NUM_LOG(3), .INIT_FULL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a), .table_read_req(rd_a), .table_write_req(wr_a),
    .table_write_addr(addr_a), .table_head_addr(head_a), .table_last_addr(last_a),
    .table_empty(empty_a), .table_full(full_a), .table_count(count_a), .table_busy(busy_a)
`ifdef LINK_MGR_ERR_FLAG_EN
    , .err_underflow(unf_a), .err_overflow(ovf_a)
`endif
  );

  link_table_addr_manager #(.ADDR_PAGE_NUM_LOG(3), .INIT_FULL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b), .table_read_req(rd_b), .table_write_req(wr_b),
    .table_write_addr(addr_b), .table_head_addr(head_b), .table_last_addr(last_b),
    .table_empty(empty_b), .table_full(full_b), .table_count(count_b), .table_busy(busy_b)
`ifdef LINK_MGR_ERR_FLAG_EN
    , .err_underflow(unf_b), .err_overflow(ovf_b)
`endif
  );

  // Snapshot layout: {head[2:0], last[2:0], count[3:0], empty, full, busy}
  logic [12:0] got, exp;

  function automatic logic [12:0] snap_a();
    return {head_a, last_a, count_a, empty_a, full_a, busy_a};
  endfunction

  function automatic logic [12:0] snap_b();
    return {head_b, last_b, count_b, empty_b, full_b, busy_b};
  endfunction

  task automatic step_a(input logic rd, input logic wr, input logic [2:0] addr);
    rd_a = rd; wr_a = wr; addr_a = addr;
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = '0;
  endtask

  task automatic step_b(input logic rd, input logic wr, input logic [2:0] addr);
    rd_b = rd; wr_b = wr; addr_b = addr;
    @(posedge clk); #1;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = '0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    rd_a = 0; wr_a = 0; addr_a = 0; rd_b = 0; wr_b = 0; addr_b = 0;
    repeat (2) @(posedge clk);
    #1;
    got = snap_a(); exp = {3'd0, 3'd7, 4'd8, 1'b1, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_a got=%h exp=%h", got, exp); end
    got = snap_b(); exp = {3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_b got=%h exp=%h", got, exp); end
`ifdef LINK_MGR_ERR_FLAG_EN
    checks++;
    if ({unf_a, ovf_a, unf_b, ovf_b} !== 4'b0000) begin
      failures++; $display("FAIL reset_err got=%b exp=0000", {unf_a, ovf_a, unf_b, ovf_b});
    end
`endif
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_init_sweep();
    // A pop and a push during the sweep must be ignored.
    for (int i = 1; i <= 7; i++) begin
      step_a(i == 3, i == 5, 3'd2);
      checks++;
      if ({busy_a, empty_a, full_a} !== 3'b110) begin
        failures++; $display("FAIL init_busy cyc=%0d got=%b exp=110", i, {busy_a, empty_a, full_a});
      end
    end
    step_a(1'b0, 1'b0, 3'd0);
    got = snap_a(); exp = {3'd0, 3'd7, 4'd8, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL init_done got=%h exp=%h", got, exp); end
`ifdef LINK_MGR_ERR_FLAG_EN
    checks++;
    if ({unf_a, ovf_a} !== 2'b00) begin failures++; $display("FAIL init_err got=%b exp=00", {unf_a, ovf_a}); end
`endif
  endtask

  task automatic test_pop_all();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (head_a !== 3'(i)) begin failures++; $display("FAIL pop_seq i=%0d got=%0d exp=%0d", i, head_a, i); end
      step_a(1'b1, 1'b0, 3'd0);
    end
    got = snap_a(); exp = {3'd7, 3'd7, 4'd0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL pop_all_end got=%h exp=%h", got, exp); end
  endtask

  task automatic test_underflow();
    step_a(1'b1, 1'b0, 3'd0);
    got = snap_a(); exp = {3'd7, 3'd7, 4'd0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL underflow_state got=%h exp=%h", got, exp); end
`ifdef LINK_MGR_ERR_FLAG_EN
    checks++;
    if ({unf_a, ovf_a} !== 2'b10) begin failures++; $display("FAIL underflow_flag got=%b exp=10", {unf_a, ovf_a}); end
`endif
  endtask

  task automatic test_push_pop();
    logic [2:0] pages [3];
    logic [12:0] exps [3];
    pages = '{3'd5, 3'd2, 3'd6};
    exps  = '{{3'd5, 3'd5, 4'd1, 3'b000}, {3'd5, 3'd2, 4'd2, 3'b000}, {3'd5, 3'd6, 4'd3, 3'b000}};
    for (int i = 0; i < 3; i++) begin
      step_b(1'b0, 1'b1, pages[i]);
      got = snap_b();
      checks++;
      if (got !== exps[i]) begin failures++; $display("FAIL push_b%0d got=%h exp=%h", i, got, exps[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (head_b !== pages[i]) begin failures++; $display("FAIL pop_b%0d got=%0d exp=%0d", i, head_b, pages[i]); end
      step_b(1'b1, 1'b0, 3'd0);
    end
    checks++;
    if ({count_b, empty_b} !== {4'd0, 1'b1}) begin
      failures++; $display("FAIL pop_b_end got=%h exp=01", {count_b, empty_b});
    end
  endtask

  task automatic test_simul_one();
    // Pop+push at count 0: only the push takes effect.
    step_b(1'b1, 1'b1, 3'd3);
    got = snap_b(); exp = {3'd3, 3'd3, 4'd1, 3'b000};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL simul_zero got=%h exp=%h", got, exp); end
    step_b(1'b1, 1'b1, 3'd4);
    got = snap_b(); exp = {3'd4, 3'd4, 4'd1, 3'b000};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL simul_one got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    step_b(1'b0, 1'b1, 3'd1);
    step_b(1'b1, 1'b1, 3'd7);
    got = snap_b(); exp = {3'd1, 3'd7, 4'd2, 3'b000};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_simul got=%h exp=%h", got, exp); end
    step_b(1'b1, 1'b0, 3'd0);
    step_b(1'b1, 1'b0, 3'd0);
    got = snap_b(); exp = {3'd7, 3'd7, 4'd0, 3'b100};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", got, exp); end
`ifdef LINK_MGR_ERR_FLAG_EN
    checks++;
    if ({unf_b, ovf_b} !== 2'b10) begin failures++; $display("FAIL b_err got=%b exp=10", {unf_b, ovf_b}); end
`endif
  endtask

  task automatic test_full();
    logic [2:0] pages [8];
    logic [2:0] order [8];
    pages = '{3'd3, 3'd1, 3'd5, 3'd0, 3'd2, 3'd6, 3'd4, 3'd7};
    order = '{3'd1, 3'd5, 3'd0, 3'd2, 3'd6, 3'd4, 3'd7, 3'd3};
    for (int i = 0; i < 8; i++) step_a(1'b0, 1'b1, pages[i]);
    got = snap_a(); exp = {3'd3, 3'd7, 4'd8, 3'b010};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL fill got=%h exp=%h", got, exp); end
    step_a(1'b0, 1'b1, 3'd2);
    got = snap_a();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL overflow_state got=%h exp=%h", got, exp); end
`ifdef LINK_MGR_ERR_FLAG_EN
    checks++;
    if ({unf_a, ovf_a} !== 2'b11) begin failures++; $display("FAIL overflow_flag got=%b exp=11", {unf_a, ovf_a}); end
`endif
    step_a(1'b1, 1'b1, 3'd3);
    got = snap_a(); exp = {3'd1, 3'd3, 4'd8, 3'b010};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL full_simul got=%h exp=%h", got, exp); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (head_a !== order[i]) begin failures++; $display("FAIL full_drain i=%0d got=%0d exp=%0d", i, head_a, order[i]); end
      step_a(1'b1, 1'b0, 3'd0);
    end
    checks++;
    if ({count_a, empty_a, full_a} !== {4'd0, 2'b10}) begin
      failures++; $display("FAIL full_drain_end got=%h exp=%h", {count_a, empty_a, full_a}, {4'd0, 2'b10});
    end
  endtask

  task automatic test_reset_mid_sweep();
    rst_a = 1'b0; #2; rst_a = 1'b1;
    repeat (4) step_a(1'b0, 1'b0, 3'd0);
    rst_a = 1'b0; #1;
    got = snap_a(); exp = {3'd0, 3'd7, 4'd8, 3'b101};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL midrst_hold got=%h exp=%h", got, exp); end
`ifdef LINK_MGR_ERR_FLAG_EN
    checks++;
    if ({unf_a, ovf_a} !== 2'b00) begin failures++; $display("FAIL midrst_err got=%b exp=00", {unf_a, ovf_a}); end
`endif
    rst_a = 1'b1;
    repeat (7) step_a(1'b0, 1'b0, 3'd0);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", busy_a); end
    step_a(1'b0, 1'b0, 3'd0);
    got = snap_a(); exp = {3'd0, 3'd7, 4'd8, 3'b010};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL midrst_done got=%h exp=%h", got, exp); end
    step_a(1'b1, 1'b0, 3'd0);
    checks++;
    if ({head_a, count_a} !== {3'd1, 4'd7}) begin
      failures++; $display("FAIL midrst_pop got=%h exp=%h", {head_a, count_a}, {3'd1, 4'd7});
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_pop_all();
    test_underflow();
    test_push_pop();
    test_simul_one();
    test_back_to_back();
    test_full();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
